countdown_bank: RTL and testbench

- Bank of N independent W-bit countdown timers sharing one write port.
- Each channel runs one-shot or periodic (auto-reload), raises a one-cycle fire pulse and a sticky expired flag on reaching zero.
- Sits beside the CPU/peripheral bus glue as the general-purpose timer source for timeouts, baud/tick generation and interrupt requests.

---
 rtl/countdown_bank.sv | 102 ++++++++++
 tb/tb_countdown_bank.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_bank.sv
// Bank of N independent W-bit countdown timers (one-shot or auto-reload) sharing one write port.
// Optional shared tick prescaler enabled by defining TIMER_PRESCALE_EN.
module countdown_bank #(
  parameter int W   = 8,
  parameter int N   = 4,
  parameter int DIV = 1,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [SW-1:0]   sel,
  input  logic [W-1:0]    value,
  input  logic            periodic,
  input  logic            put,
  input  logic [N-1:0]    ack,
  output logic [N*W-1:0]  count,
  output logic [N-1:0]    fire,
  output logic [N-1:0]    expired
);

  logic tick;

`ifdef TIMER_PRESCALE_EN
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = (presc_q == PW'(DIV - 1)) ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = (presc_q == PW'(DIV - 1));
`else
  // Without the prescaler every edge ticks; any legal DIV (>=1) makes this constant 1.
  assign tick = (DIV >= 1);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      logic [W-1:0] count_q, count_d;
      logic [W-1:0] reload_q, reload_d;
      logic         mode_q, mode_d;
      logic         fire_q, fire_d;
      logic         exp_q, exp_d;
      logic         put_hit;

      // Out-of-range select codes never match any channel, so they are dropped.
      assign put_hit = put && (sel == SW'(gi));

      always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        fire_d   = 1'b0;
        exp_d    = exp_q & ~ack[gi];
        if (put_hit) begin
          count_d  = value;
          reload_d = value;
          mode_d   = periodic;
        end else if (tick) begin
          if (count_q > W'(1)) begin
            count_d = count_q - W'(1);
          end else if (count_q == W'(1)) begin
            fire_d  = 1'b1;
            exp_d   = 1'b1;
            count_d = (mode_q && (reload_q != '0)) ? reload_q : '0;
          end
        end
      end

      always_ff @(posedge clock) begin
        if (!reset) begin
          count_q  <= '0;
          reload_q <= '0;
          mode_q   <= 1'b0;
          fire_q   <= 1'b0;
          exp_q    <= 1'b0;
        end else begin
          count_q  <= count_d;
          reload_q <= reload_d;
          mode_q   <= mode_d;
          fire_q   <= fire_d;
          exp_q    <= exp_d;
        end
      end

      assign count[gi*W +: W] = count_q;
      assign fire[gi]         = fire_q;
      assign expired[gi]      = exp_q;
    end
  endgenerate

endmodule

// File: tb/tb_countdown_bank.sv
// Directed bench for countdown_bank: one task per scenario, N=4 main instance plus an N=3 instance.
module tb_countdown_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic [7:0]  value;
  logic        periodic;
  logic        put;
  logic [3:0]  ack;
  logic [31:0] count;
  logic [3:0]  fire;
  logic [3:0]  expired;

  logic [1:0]  sel3;
  logic [7:0]  value3;
  logic        periodic3;
  logic        put3;
  logic [2:0]  ack3;
  logic [23:0] count3;
  logic [2:0]  fire3;
  logic [2:0]  expired3;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  countdown_bank #(.W(8), .N(4)) dut (
    .clock(clock), .reset(reset), .sel(sel), .value(value), .periodic(periodic),
    .put(put), .ack(ack), .count(count), .fire(fire), .expired(expired)
  );

  countdown_bank #(.W(8), .N(3)) dut3 (
    .clock(clock), .reset(reset), .sel(sel3), .value(value3), .periodic(periodic3),
    .put(put3), .ack(ack3), .count(count3), .fire(fire3), .expired(expired3)
  );

`ifdef TIMER_PRESCALE_EN
  logic        reset4;
  logic [1:0]  sel4;
  logic [7:0]  value4;
  logic        periodic4;
  logic        put4;
  logic [3:0]  ack4;
  logic [31:0] count4;
  logic [3:0]  fire4;
  logic [3:0]  expired4;

  countdown_bank #(.W(8), .N(4), .DIV(4)) dut4 (
    .clock(clock), .reset(reset4), .sel(sel4), .value(value4), .periodic(periodic4),
    .put(put4), .ack(ack4), .count(count4), .fire(fire4), .expired(expired4)
  );
`endif

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] cnt(int ch);
    return count[ch*8 +: 8];
  endfunction

  task automatic do_put(input logic [1:0] s, input logic [7:0] v, input logic p);
    sel = s; value = v; periodic = p; put = 1'b1;
    step();
    put = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    tests++;
    if (count !== 32'h0 || fire !== 4'h0 || expired !== 4'h0) begin
      fails++;
      $display("FAIL reset_state count=%h fire=%b expired=%b, want 0/0/0", count, fire, expired);
    end
    tests++;
    if (count3 !== 24'h0) begin
      fails++;
      $display("FAIL reset_state_n3 count3=%h, want 0", count3);
    end
    reset = 1'b1;
    step();
    $display("[TB] reset checked");
  endtask

  task automatic test_oneshot();
    do_put(2'd2, 8'd5, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      tests++;
      if (cnt(2) !== 8'(5 - i) || fire[2] !== (i == 5)) begin
        fails++;
        $display("FAIL oneshot_seq i=%0d count=%0d fire=%b, want %0d/%b", i, cnt(2), fire[2], 5 - i, (i == 5));
      end
      step();
    end
    tests++;
    if (cnt(2) !== 8'd0 || fire[2] !== 1'b0 || expired[2] !== 1'b1) begin
      fails++;
      $display("FAIL oneshot_after count=%0d fire=%b exp=%b, want 0/0/1", cnt(2), fire[2], expired[2]);
    end
    tests++;
    if (cnt(0) !== 8'd0 || cnt(1) !== 8'd0 || cnt(3) !== 8'd0 || expired !== 4'b0100) begin
      fails++;
      $display("FAIL oneshot_others count=%h expired=%b, want ch2-only", count, expired);
    end
    $display("[TB] oneshot ch2 value 5 done");
  endtask

  task automatic test_periodic();
    do_put(2'd0, 8'd3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (cnt(0) !== 8'(3 - (i % 3)) || fire[0] !== (i > 0 && i % 3 == 0)) begin
        fails++;
        $display("FAIL periodic_seq i=%0d count=%0d fire=%b, want %0d/%b", i, cnt(0), fire[0],
                 3 - (i % 3), (i > 0 && i % 3 == 0));
      end
      step();
    end
    // Now count[0]=2, so the next edge is not an expiry.
    ack = 4'b0001;
    step();
    ack = 4'b0000;
    tests++;
    if (expired[0] !== 1'b0 || expired[2] !== 1'b1 || cnt(0) !== 8'd1) begin
      fails++;
      $display("FAIL periodic_ack exp0=%b exp2=%b count0=%0d, want 0/1/1", expired[0], expired[2], cnt(0));
    end
    $display("[TB] periodic ch0 value 3 and ack done");
  endtask

  task automatic test_put_wins_and_ack();
    do_put(2'd1, 8'd2, 1'b0);
    step();
    tests++;
    if (cnt(1) !== 8'd1) begin
      fails++;
      $display("FAIL putwin_setup count1=%0d, want 1", cnt(1));
    end
    do_put(2'd1, 8'd7, 1'b0);
    tests++;
    if (cnt(1) !== 8'd7 || fire[1] !== 1'b0 || expired[1] !== 1'b0) begin
      fails++;
      $display("FAIL putwin count1=%0d fire1=%b exp1=%b, want 7/0/0", cnt(1), fire[1], expired[1]);
    end
    do_put(2'd3, 8'd2, 1'b0);
    step();
    ack = 4'b1000;
    step();
    ack = 4'b0000;
    tests++;
    if (expired[3] !== 1'b1 || fire[3] !== 1'b1 || cnt(3) !== 8'd0) begin
      fails++;
      $display("FAIL ack_vs_expiry exp3=%b fire3=%b count3=%0d, want 1/1/0", expired[3], fire[3], cnt(3));
    end
    ack = 4'b1000;
    step();
    ack = 4'b0000;
    tests++;
    if (expired[3] !== 1'b0 || fire[3] !== 1'b0) begin
      fails++;
      $display("FAIL ack_clear exp3=%b fire3=%b, want 0/0", expired[3], fire[3]);
    end
    $display("[TB] put-wins and ack-vs-expiry done");
  endtask

  task automatic test_zero_load();
    int fired = 0;
    do_put(2'd1, 8'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (fire[1] !== 1'b0 || cnt(1) !== 8'd0) fired++;
      step();
    end
    tests++;
    if (fired != 0 || expired[1] !== 1'b0) begin
      fails++;
      $display("FAIL zero_load bad_cycles=%0d exp1=%b, want 0/0", fired, expired[1]);
    end
    $display("[TB] zero load ch1 done");
  endtask

  task automatic test_bad_sel();
    sel3 = 2'd3; value3 = 8'd9; periodic3 = 1'b0; put3 = 1'b1;
    step();
    tests++;
    if (count3 !== 24'h0 || fire3 !== 3'b0) begin
      fails++;
      $display("FAIL badsel_idle count3=%h fire3=%b, want 0/0", count3, fire3);
    end
    sel3 = 2'd2;
    step();
    sel3 = 2'd3; value3 = 8'd5;
    step();
    put3 = 1'b0;
    tests++;
    if (count3 !== 24'h08_00_00) begin
      fails++;
      $display("FAIL badsel_loaded count3=%h, want 080000", count3);
    end
    $display("[TB] N=3 out-of-range select done");
  endtask

  task automatic test_reset_mid();
    do_put(2'd0, 8'd4, 1'b0);
    do_put(2'd3, 8'd4, 1'b0);
    step();
    tests++;
    if (cnt(0) !== 8'd2 || cnt(3) !== 8'd3) begin
      fails++;
      $display("FAIL resetmid_setup count0=%0d count3=%0d, want 2/3", cnt(0), cnt(3));
    end
    reset = 1'b0;
    step();
    tests++;
    if (count !== 32'h0 || fire !== 4'h0 || expired !== 4'h0) begin
      fails++;
      $display("FAIL resetmid count=%h fire=%b exp=%b, want 0", count, fire, expired);
    end
    sel = 2'd0; value = 8'd9; periodic = 1'b1; put = 1'b1;
    step();
    step();
    tests++;
    if (count !== 32'h0) begin
      fails++;
      $display("FAIL reset_over_put count=%h, want 0", count);
    end
    put = 1'b0;
    reset = 1'b1;
    step();
    $display("[TB] mid-count reset done");
  endtask

`ifdef TIMER_PRESCALE_EN
  task automatic test_prescale();
    reset4 = 1'b0;
    step();
    reset4 = 1'b1;
    sel4 = 2'd0; value4 = 8'd2; periodic4 = 1'b0; put4 = 1'b1;
    step();
    put4 = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      logic [7:0] ec;
      logic       ef;
      ec = (k <= 2) ? 8'd2 : (k <= 6) ? 8'd1 : 8'd0;
      ef = (k == 7);
      tests++;
      if (count4[7:0] !== ec || fire4[0] !== ef) begin
        fails++;
        $display("FAIL prescale k=%0d count=%0d fire=%b, want %0d/%b", k, count4[7:0], fire4[0], ec, ef);
      end
      step();
    end
    $display("[TB] prescale DIV=4 done");
  endtask
`endif

  initial begin
    reset = 1'b0; sel = '0; value = '0; periodic = 1'b0; put = 1'b0; ack = '0;
    sel3 = '0; value3 = '0; periodic3 = 1'b0; put3 = 1'b0; ack3 = '0;
`ifdef TIMER_PRESCALE_EN
    reset4 = 1'b0; sel4 = '0; value4 = '0; periodic4 = 1'b0; put4 = 1'b0; ack4 = '0;
`endif
    test_reset();
    test_oneshot();
    test_periodic();
    test_put_wins_and_ack();
    test_zero_load();
    test_bad_sel();
    test_reset_mid();
`ifdef TIMER_PRESCALE_EN
    test_prescale();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
